can_tx_fifo: RTL and testbench
==============================

// Module: can_tx_fifo
// PURPOSE
//  Transmit-side frame buffer between the host register interface and the CAN bit-level transmitter.
//  The host writes TX buffer registers into a staging slot and commits the slot with a transmit request.
//  The transmitter fetches bytes of the oldest committed frame by index and releases the slot when done.
//  Storage is fixed 16-byte slots, 2**PKT_BITS slots, one dual-port RAM (host write, core read).
// PARAMETERS
//  PKT_BITS  4  log2 of slot count (16 frames); RAM = 2**PKT_BITS*16 x 8
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-high
//  reset_mode     in   1   controller reset mode; synchronous flush of all state
//  extended_mode  in   1   1: TX window addr 16..28; 0: TX window addr 10..19
//  host_wr        in   1   host register write strobe (one cycle per byte)
//  host_addr      in   6   host register address
//  host_data      in   8   host write data
//  tx_request     in   1   commit staging slot as a pending frame (1-cycle pulse)
//  abort_tx       in   1   abort head frame (1-cycle pulse)
//  clr_ovr        in   1   clear overflow flag (1-cycle pulse)
//  core_start     in   1   transmitter begins sending head frame
//  core_done      in   1   transmitter finished head frame (success or arbitration giveup)
//  core_rd_idx    in   4   byte index within head slot
//  core_data      out  8   RAM[{rpkt,core_rd_idx}], registered, 1-cycle latency
//  tx_pending     out  1   head slot READY (committed, not started)
//  tx_active      out  1   head slot ACTIVE
//  tx_aborted     out  1   pulse: head frame dropped by abort
//  full           out  1   count == 2**PKT_BITS
//  count          out  PKT_BITS+1  committed frames not yet released
//  ovr            out  1   sticky: tx_request refused because full
// BEHAVIOUR
//  Reset (rst or reset_mode): wpkt=rpkt=0, count=0, head FSM=EMPTY, all outputs 0 except core_data (RAM, unreset).
//  Host address map: ext: byte=addr-16 valid for 16..28; normal: byte=addr-10 valid for 10..19; else write ignored.
//  Write: host_wr && valid && !full -> RAM[{wpkt,byte}] <= host_data same cycle; writes while full dropped.
//  Staging slot = wpkt; re-writing a byte before commit overwrites it; unwritten bytes hold stale data.
//  Commit: tx_request && !full -> wpkt <= wpkt+1 (wraps mod 2**PKT_BITS), count+1.
//  tx_request && full -> no pointer change, ovr <= 1; ovr cleared only by clr_ovr or reset; set wins over clear.
//  Head FSM (state of slot rpkt):
//   EMPTY : count!=0 -> READY (next cycle)
//   READY : core_start -> ACTIVE; abort_tx -> release, tx_aborted pulse, -> EMPTY/READY per new count
//   ACTIVE: core_done -> release -> EMPTY/READY; abort_tx latches abort_pend, frame still completes
//           (no mid-frame stop); on core_done with abort_pend -> tx_aborted pulse, abort_pend cleared
//  core_start in EMPTY ignored; core_done outside ACTIVE ignored; abort_tx in EMPTY ignored.
//  Release: rpkt <= rpkt+1 (wraps), count-1.
//  Same-cycle commit and release: both pointers advance, count unchanged; full/ovr judged on pre-cycle count.
//  Release same cycle as commit from count=1: FSM -> READY on next cycle (new head).
//  Read port: core_data updated every cycle from {rpkt,core_rd_idx}; independent of host writes;
//   same-address write/read same cycle returns old data.
//  full/count/tx_pending/tx_active are registered-state decodes, valid the cycle after the causing event.
//  reset_mode asserted mid-ACTIVE: frame discarded, no tx_aborted pulse; core must honour reset_mode itself.
// TESTING
//  Ext mode: write addr16..28 = 0x00..0x0C, tx_request -> count=1, tx_pending=1; idx0..12 -> core_data 0x00..0x0C, 1 clk late.
//  Normal mode: write addr9=0xAA, addr10=0x55 -> idx0=0x55, addr9 ignored; addr20 ignored.
//  Commit 16 frames -> full=1, count=16; 17th tx_request -> ovr=1, count=16; clr_ovr -> ovr=0.
//  count=3 head ACTIVE: core_done and tx_request same cycle -> count=3, rpkt+1, wpkt+1, FSM READY.
//  abort_tx in READY -> tx_aborted pulse, count-1; abort_tx in ACTIVE -> no drop until core_done, then tx_aborted.
//  Wrap: 40 commit/release cycles -> pointers wrap 15->0, data of frame 17 correct; reset_mode mid-ACTIVE -> count=0.

Source files
------------

// File: rtl/can_tx_fifo_if.sv
// Host/transmitter-side signal bundle for the CAN TX frame buffer.
// master drives the host and core controls, slave is the buffer itself.
interface can_tx_fifo_if #(
    parameter int PKT_BITS = 4
);
    logic                i_reset_mode;
    logic                i_extended_mode;
    logic                i_host_wr;
    logic [5:0]          i_host_addr;
    logic [7:0]          i_host_data;
    logic                i_tx_request;
    logic                i_abort_tx;
    logic                i_clr_ovr;
    logic                i_core_start;
    logic                i_core_done;
    logic [3:0]          i_core_rd_idx;
    logic [7:0]          o_core_data;
    logic                o_tx_pending;
    logic                o_tx_active;
    logic                o_tx_aborted;
    logic                o_full;
    logic [PKT_BITS:0]   o_count;
    logic                o_ovr;

    modport master (
        output i_reset_mode, i_extended_mode, i_host_wr, i_host_addr, i_host_data,
               i_tx_request, i_abort_tx, i_clr_ovr, i_core_start, i_core_done,
               i_core_rd_idx,
        input  o_core_data, o_tx_pending, o_tx_active, o_tx_aborted, o_full,
               o_count, o_ovr
    );

    modport slave (
        input  i_reset_mode, i_extended_mode, i_host_wr, i_host_addr, i_host_data,
               i_tx_request, i_abort_tx, i_clr_ovr, i_core_start, i_core_done,
               i_core_rd_idx,
        output o_core_data, o_tx_pending, o_tx_active, o_tx_aborted, o_full,
               o_count, o_ovr
    );
endinterface

// File: rtl/can_tx_fifo.sv
// CAN transmit frame buffer: host stages 16-byte slots and commits them, the
// bit-level transmitter reads the oldest committed slot and releases it.
module can_tx_fifo #(
    parameter int PKT_BITS = 4
) (
    input logic          clk,
    input logic          rst,
    can_tx_fifo_if.slave bus
);
    localparam int SLOTS = 2 ** PKT_BITS;
    localparam int DEPTH = SLOTS * 16;
    localparam logic [PKT_BITS:0]   FULL_COUNT = (PKT_BITS + 1)'(SLOTS);
    localparam logic [PKT_BITS:0]   CNT_ONE    = (PKT_BITS + 1)'(1);
    localparam logic [PKT_BITS:0]   CNT_ZERO   = (PKT_BITS + 1)'(0);
    localparam logic [PKT_BITS-1:0] PTR_ONE    = PKT_BITS'(1);
    localparam logic [PKT_BITS-1:0] PTR_ZERO   = PKT_BITS'(0);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_READY  = 2'd1,
        ST_ACTIVE = 2'd2
    } head_state_t;

    logic [7:0]          r_mem [DEPTH];
    logic [7:0]          r_core_data;
    logic [PKT_BITS-1:0] r_wpkt;
    logic [PKT_BITS-1:0] r_rpkt;
    logic [PKT_BITS:0]   r_count;
    head_state_t         r_state;
    logic                r_abort_pend;
    logic                r_full;
    logic                r_ovr;
    logic                r_tx_pending;
    logic                r_tx_active;
    logic                r_tx_aborted;

    logic [3:0]          w_byte;
    logic                w_addr_valid;
    logic                w_wr_en;
    logic                w_commit;
    logic                w_release;
    logic                w_abort_evt;
    logic [PKT_BITS:0]   w_count_nxt;
    head_state_t         w_state_nxt;

    // Both windows share the low nibble: addr-16 == addr[3:0], addr-10 wraps mod 16.
    assign w_byte = bus.i_extended_mode ? bus.i_host_addr[3:0]
                                        : (bus.i_host_addr[3:0] - 4'd10);
    assign w_addr_valid = bus.i_extended_mode
                        ? ((bus.i_host_addr >= 6'd16) && (bus.i_host_addr <= 6'd28))
                        : ((bus.i_host_addr >= 6'd10) && (bus.i_host_addr <= 6'd19));
    assign w_wr_en  = bus.i_host_wr && w_addr_valid && !r_full && !bus.i_reset_mode;
    assign w_commit = bus.i_tx_request && !r_full;

    // Host write into the staging slot.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wpkt, w_byte}] <= bus.i_host_data;
        end
    end

    // Core read port; old data is returned on a same-address collision.
    always_ff @(posedge clk) begin
        r_core_data <= r_mem[{r_rpkt, bus.i_core_rd_idx}];
    end

    // Head-slot release/abort decisions and the next pointer/count/state.
    always_comb begin
        w_release   = 1'b0;
        w_abort_evt = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_READY: begin
                if (bus.i_core_start) begin
                    w_release = 1'b0;
                end else if (bus.i_abort_tx) begin
                    w_release   = 1'b1;
                    w_abort_evt = 1'b1;
                end else begin
                    w_release = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (bus.i_core_done) begin
                    w_release   = 1'b1;
                    w_abort_evt = r_abort_pend;
                end else begin
                    w_release = 1'b0;
                end
            end
            default: begin
                w_release = 1'b0;
            end
        endcase

        case ({w_commit, w_release})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase

        case (r_state)
            ST_EMPTY: begin
                w_state_nxt = (r_count != CNT_ZERO) ? ST_READY : ST_EMPTY;
            end
            ST_READY: begin
                if (bus.i_core_start) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_release) begin
                    w_state_nxt = (w_count_nxt != CNT_ZERO) ? ST_READY : ST_EMPTY;
                end else begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_ACTIVE: begin
                if (w_release) begin
                    w_state_nxt = (w_count_nxt != CNT_ZERO) ? ST_READY : ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Pointers, count, head FSM and the registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wpkt       <= PTR_ZERO;
            r_rpkt       <= PTR_ZERO;
            r_count      <= CNT_ZERO;
            r_state      <= ST_EMPTY;
            r_abort_pend <= 1'b0;
            r_full       <= 1'b0;
            r_ovr        <= 1'b0;
            r_tx_pending <= 1'b0;
            r_tx_active  <= 1'b0;
            r_tx_aborted <= 1'b0;
        end else if (bus.i_reset_mode) begin
            r_wpkt       <= PTR_ZERO;
            r_rpkt       <= PTR_ZERO;
            r_count      <= CNT_ZERO;
            r_state      <= ST_EMPTY;
            r_abort_pend <= 1'b0;
            r_full       <= 1'b0;
            r_ovr        <= 1'b0;
            r_tx_pending <= 1'b0;
            r_tx_active  <= 1'b0;
            r_tx_aborted <= 1'b0;
        end else begin
            r_wpkt       <= w_commit  ? (r_wpkt + PTR_ONE) : r_wpkt;
            r_rpkt       <= w_release ? (r_rpkt + PTR_ONE) : r_rpkt;
            r_count      <= w_count_nxt;
            r_state      <= w_state_nxt;
            // An abort during transmission waits for the frame to finish.
            r_abort_pend <= (r_state == ST_ACTIVE) && !bus.i_core_done
                            && (r_abort_pend || bus.i_abort_tx);
            r_full       <= (w_count_nxt == FULL_COUNT);
            if (bus.i_tx_request && r_full) begin
                r_ovr <= 1'b1;
            end else if (bus.i_clr_ovr) begin
                r_ovr <= 1'b0;
            end else begin
                r_ovr <= r_ovr;
            end
            r_tx_pending <= (w_state_nxt == ST_READY);
            r_tx_active  <= (w_state_nxt == ST_ACTIVE);
            r_tx_aborted <= w_abort_evt;
        end
    end

    assign bus.o_core_data  = r_core_data;
    assign bus.o_tx_pending = r_tx_pending;
    assign bus.o_tx_active  = r_tx_active;
    assign bus.o_tx_aborted = r_tx_aborted;
    assign bus.o_full       = r_full;
    assign bus.o_count      = r_count;
    assign bus.o_ovr        = r_ovr;
endmodule

// File: tb/tb_can_tx_fifo.sv
// Self-checking bench for can_tx_fifo: address-map vector table, directed
// multi-cycle sequences and a randomized run against a frame-level model.
module tb_can_tx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    can_tx_fifo_if #(.PKT_BITS(4)) bus ();
    can_tx_fifo #(.PKT_BITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit         rm;
        bit         wr;
        logic [5:0] addr;
        logic [7:0] data;
        bit         req;
        bit         abt;
        bit         clr;
        bit         st;
        bit         dn;
        logic [3:0] idx;
    } stim_t;

    typedef struct {
        bit         ext;
        logic [5:0] addr;
        logic [7:0] data;
        bit         valid;
        logic [3:0] bidx;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit cur_ext = 1'b1;

    // Frame-level model: slot ring as flat byte array, head status 0/1/2 = empty/ready/active
    int   m_w = 0, m_r = 0, m_cnt = 0, m_head = 0;
    bit   m_ap = 0, m_ovr = 0, m_abt = 0;
    logic [7:0] mm [256];
    bit   mk [256];
    logic [7:0] exp_core;
    bit   exp_known = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic model_step(input stim_t s);
        int b;
        bit valid, full, commit, rel;
        exp_known = mk[m_r * 16 + int'(s.idx)];
        exp_core  = mm[m_r * 16 + int'(s.idx)];
        if (s.rm) begin
            m_w = 0; m_r = 0; m_cnt = 0; m_head = 0; m_ap = 0; m_ovr = 0; m_abt = 0;
            return;
        end
        full = (m_cnt == 16);
        if (cur_ext) begin
            valid = (s.addr >= 16 && s.addr <= 28);
            b = int'(s.addr) - 16;
        end else begin
            valid = (s.addr >= 10 && s.addr <= 19);
            b = int'(s.addr) - 10;
        end
        if (s.wr && valid && !full) begin
            mm[m_w * 16 + b] = s.data;
            mk[m_w * 16 + b] = 1'b1;
        end
        commit = s.req && !full;
        if (s.req && full) m_ovr = 1'b1;
        else if (s.clr) m_ovr = 1'b0;
        rel = 0;
        m_abt = 0;
        case (m_head)
            0: m_head = (m_cnt > 0) ? 1 : 0;
            1: begin
                if (s.st) m_head = 2;
                else if (s.abt) begin rel = 1; m_abt = 1; end
            end
            default: begin
                if (s.dn) begin rel = 1; m_abt = m_ap; m_ap = 0; end
                else if (s.abt) m_ap = 1;
            end
        endcase
        m_cnt = m_cnt + int'(commit) - int'(rel);
        m_w = (m_w + int'(commit)) % 16;
        m_r = (m_r + int'(rel)) % 16;
        if (rel) m_head = (m_cnt > 0) ? 1 : 0;
    endtask

    // One clock: drive at negedge, update model, compare at the next negedge.
    task automatic cyc(input stim_t s);
        bus.i_reset_mode    = s.rm;
        bus.i_extended_mode = cur_ext;
        bus.i_host_wr       = s.wr;
        bus.i_host_addr     = s.addr;
        bus.i_host_data     = s.data;
        bus.i_tx_request    = s.req;
        bus.i_abort_tx      = s.abt;
        bus.i_clr_ovr       = s.clr;
        bus.i_core_start    = s.st;
        bus.i_core_done     = s.dn;
        bus.i_core_rd_idx   = s.idx;
        model_step(s);
        @(negedge clk);
        chk("m_count", int'(bus.o_count), m_cnt);
        chk("m_full", int'(bus.o_full), int'(m_cnt == 16));
        chk("m_pending", int'(bus.o_tx_pending), int'(m_head == 1));
        chk("m_active", int'(bus.o_tx_active), int'(m_head == 2));
        chk("m_aborted", int'(bus.o_tx_aborted), int'(m_abt));
        chk("m_ovr", int'(bus.o_ovr), int'(m_ovr));
        if (exp_known) chk("m_core_data", int'(bus.o_core_data), int'(exp_core));
    endtask

    task automatic flush();
        stim_t s = idle();
        s.rm = 1'b1;
        cyc(s);
    endtask

    task automatic hwr(input logic [5:0] a, input logic [7:0] d);
        stim_t s = idle();
        s.wr = 1'b1; s.addr = a; s.data = d;
        cyc(s);
    endtask

    task automatic ctl(input bit req, input bit abt, input bit st, input bit dn, input bit clr);
        stim_t s = idle();
        s.req = req; s.abt = abt; s.st = st; s.dn = dn; s.clr = clr;
        cyc(s);
    endtask

    task automatic rd(input logic [3:0] i);
        stim_t s = idle();
        s.idx = i;
        cyc(s);
    endtask

    vec_t vt [11];

    initial begin
        stim_t s;
        vt[0]  = '{1'b1, 6'd16, 8'h11, 1'b1, 4'd0};
        vt[1]  = '{1'b1, 6'd28, 8'h22, 1'b1, 4'd12};
        vt[2]  = '{1'b1, 6'd15, 8'h33, 1'b0, 4'd0};
        vt[3]  = '{1'b1, 6'd29, 8'h44, 1'b0, 4'd0};
        vt[4]  = '{1'b1, 6'd20, 8'h5A, 1'b1, 4'd4};
        vt[5]  = '{1'b1, 6'd10, 8'h66, 1'b0, 4'd0};
        vt[6]  = '{1'b0, 6'd9,  8'hAA, 1'b0, 4'd0};
        vt[7]  = '{1'b0, 6'd10, 8'h55, 1'b1, 4'd0};
        vt[8]  = '{1'b0, 6'd19, 8'h67, 1'b1, 4'd9};
        vt[9]  = '{1'b0, 6'd20, 8'h77, 1'b0, 4'd0};
        vt[10] = '{1'b0, 6'd16, 8'h88, 1'b1, 4'd6};
        for (int i = 0; i < 256; i++) begin mk[i] = 1'b0; mm[i] = 8'h00; end

        s = idle();
        bus.i_reset_mode = 1'b0; bus.i_extended_mode = 1'b1; bus.i_host_wr = 1'b0;
        bus.i_host_addr = 6'd0; bus.i_host_data = 8'h00; bus.i_tx_request = 1'b0;
        bus.i_abort_tx = 1'b0; bus.i_clr_ovr = 1'b0; bus.i_core_start = 1'b0;
        bus.i_core_done = 1'b0; bus.i_core_rd_idx = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_count", int'(bus.o_count), 0);
        chk("rst_full", int'(bus.o_full), 0);
        chk("rst_pending", int'(bus.o_tx_pending), 0);
        chk("rst_active", int'(bus.o_tx_active), 0);
        chk("rst_ovr", int'(bus.o_ovr), 0);

        // Extended window 16..28 carrying bytes 0x00..0x0C
        cur_ext = 1'b1;
        flush();
        for (int i = 0; i < 13; i++) hwr(6'(16 + i), 8'(i));
        ctl(1, 0, 0, 0, 0);
        ctl(0, 0, 0, 0, 0);
        chk("ext_count", int'(bus.o_count), 1);
        chk("ext_pending", int'(bus.o_tx_pending), 1);
        for (int i = 0; i < 13; i++) begin
            rd(4'(i));
            chk("ext_data", int'(bus.o_core_data), i);
        end

        // Address-map table: prime slot 0 with 0xEE, write one vector, read back bytes 0..12
        foreach (vt[v]) begin
            cur_ext = 1'b1;
            flush();
            for (int i = 0; i < 13; i++) hwr(6'(16 + i), 8'hEE);
            cur_ext = vt[v].ext;
            hwr(vt[v].addr, vt[v].data);
            for (int i = 0; i < 13; i++) begin
                rd(4'(i));
                chk($sformatf("map%0d_b%0d", v, i), int'(bus.o_core_data),
                    (vt[v].valid && i == int'(vt[v].bidx)) ? int'(vt[v].data) : 32'hEE);
            end
        end

        // Fill to 16, overflow on the 17th, clear overflow
        cur_ext = 1'b1;
        flush();
        for (int i = 0; i < 16; i++) ctl(1, 0, 0, 0, 0);
        chk("fill_count", int'(bus.o_count), 16);
        chk("fill_full", int'(bus.o_full), 1);
        ctl(1, 0, 0, 0, 0);
        chk("ovr_set", int'(bus.o_ovr), 1);
        chk("ovr_count", int'(bus.o_count), 16);
        ctl(0, 0, 0, 0, 1);
        chk("ovr_clr", int'(bus.o_ovr), 0);

        // count=3 with ACTIVE head: done and request in the same cycle
        flush();
        for (int i = 0; i < 3; i++) ctl(1, 0, 0, 0, 0);
        ctl(0, 0, 1, 0, 0);
        chk("c3_active", int'(bus.o_tx_active), 1);
        ctl(1, 0, 0, 1, 0);
        chk("c3_count", int'(bus.o_count), 3);
        chk("c3_ready", int'(bus.o_tx_pending), 1);
        // Abort while READY drops at once; while ACTIVE waits for done
        ctl(0, 1, 0, 0, 0);
        chk("abr_pulse", int'(bus.o_tx_aborted), 1);
        chk("abr_count", int'(bus.o_count), 2);
        ctl(0, 0, 0, 0, 0);
        chk("abr_pulse_end", int'(bus.o_tx_aborted), 0);
        ctl(0, 0, 1, 0, 0);
        ctl(0, 1, 0, 0, 0);
        chk("aba_hold_cnt", int'(bus.o_count), 2);
        chk("aba_no_pulse", int'(bus.o_tx_aborted), 0);
        chk("aba_active", int'(bus.o_tx_active), 1);
        ctl(0, 0, 0, 0, 0);
        ctl(0, 0, 0, 1, 0);
        chk("aba_pulse", int'(bus.o_tx_aborted), 1);
        chk("aba_count", int'(bus.o_count), 1);

        // 40 frames through the ring; pointers wrap after slot 15
        flush();
        for (int f = 0; f < 40; f++) begin
            hwr(6'd16, 8'(f + 8'h30));
            ctl(1, 0, 0, 0, 0);
            ctl(0, 0, 0, 0, 0);
            ctl(0, 0, 1, 0, 0);
            chk($sformatf("wrap_f%0d", f), int'(bus.o_core_data), f + 32'h30);
            ctl(0, 0, 0, 1, 0);
        end
        chk("wrap_count", int'(bus.o_count), 0);

        // reset_mode during an active frame discards it silently
        hwr(6'd16, 8'h99);
        ctl(1, 0, 0, 0, 0);
        ctl(0, 0, 0, 0, 0);
        ctl(0, 0, 1, 0, 0);
        flush();
        chk("rm_count", int'(bus.o_count), 0);
        chk("rm_active", int'(bus.o_tx_active), 0);
        chk("rm_aborted", int'(bus.o_tx_aborted), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int op;
            s = idle();
            cur_ext = ($urandom_range(0, 7) != 0) ? cur_ext : ~cur_ext;
            s.rm   = ($urandom_range(0, 299) == 0);
            s.wr   = $urandom_range(0, 1) == 1;
            s.addr = 6'($urandom_range(0, 63));
            s.data = 8'($urandom);
            s.req  = ($urandom_range(0, 9) < 3);
            s.clr  = ($urandom_range(0, 19) == 0);
            s.idx  = 4'($urandom_range(0, 15));
            op = $urandom_range(0, 9);
            s.st = (op == 0);
            s.abt = (op == 1);
            s.dn = (op == 2);
            cyc(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
